i2c_target: RTL and testbench

I2C target (responder) that emulates the heart-rate sensor end of the bus, holding a small register file and answering the I2C initiator already in the design. It samples SCL/SDA on the system clock and drives SDA open-drain. The block is used in benches and in a standalone sensor-emulator build. A local port lets the surrounding logic load sample values and observe writes made by the initiator.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_cond.sv | 62 ++++++
 rtl/i2c_target.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state codes, R/W bit values and bit-counter width.
package i2c_pkg;

    localparam int BIT_CNT_W = 3;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ADDR   = 4'd1;
    localparam logic [3:0] ST_A_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR    = 4'd3;
    localparam logic [3:0] ST_P_ACK  = 4'd4;
    localparam logic [3:0] ST_WR     = 4'd5;
    localparam logic [3:0] ST_W_ACK  = 4'd6;
    localparam logic [3:0] ST_RD     = 4'd7;
    localparam logic [3:0] ST_M_ACK  = 4'd8;
    localparam logic [3:0] ST_IGNORE = 4'd9;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C pin: 2-flop synchronizer, optional 3-sample stability filter
// (I2C_TARGET_GLITCH_FILTER_EN), then a history flop producing rise/fall strobes.
module i2c_line_cond (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic hist;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic samp1;
    logic samp2;
    logic filt;

    // Idle bus level is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            samp1 <= 1'b1;
            samp2 <= 1'b1;
            filt  <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            samp1 <= sync2;
            samp2 <= samp1;
            if ((sync2 == samp1) && (samp1 == samp2)) begin
                filt <= sync2;
            end
            hist <= filt;
        end
    end

    assign level = filt;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign level = sync2;
`endif

    assign rise = level & ~hist;
    assign fall = ~level & hist;

endmodule

// File: rtl/i2c_target.sv
// I2C target emulating a sensor register file with a local load/observe port.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a stability filter on both lines.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h57,
    parameter int         NREG     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scl_in,
    input  logic                    sda_in,
    output logic                    sda_oe,
    input  logic                    loc_we,
    input  logic [$clog2(NREG)-1:0] loc_addr,
    input  logic [7:0]              loc_wdata,
    output logic [7:0]              loc_rdata,
    output logic                    rx_valid,
    output logic [$clog2(NREG)-1:0] rx_reg,
    output logic [7:0]              rx_data,
    output logic                    busy
);

    localparam int AW = $clog2(NREG);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_cond u_scl (
        .clk   (clk),
        .reset (reset),
        .pin   (scl_in),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_cond u_sda (
        .clk   (clk),
        .reset (reset),
        .pin   (sda_in),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic [3:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shreg;
    logic [AW-1:0]        ptr;
    logic [AW-1:0]        ptr_next;
    logic                 ack_phase;
    logic [7:0]           regs [NREG];
    logic [7:0]           rx_byte;
    logic                 start_det;
    logic                 stop_det;
    logic                 byte_done;
    logic                 i2c_we;

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;
    assign rx_byte   = {shreg[6:0], sda_level};
    assign byte_done = scl_rise & (&bit_cnt);
    assign ptr_next  = ptr + 1'b1;
    assign i2c_we    = (state == ST_WR) & byte_done & ~start_det & ~stop_det;
    assign loc_rdata = regs[loc_addr];

    // Local write is issued after the I2C write so it wins on a same-index collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (i2c_we) begin
                regs[ptr] <= rx_byte;
            end
            if (loc_we) begin
                regs[loc_addr] <= loc_wdata;
            end
        end
    end

    // ack_phase splits each ACK slot: first SCL fall starts the ack bit, second ends it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= 8'h00;
            ptr       <= '0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rx_valid  <= 1'b0;
            rx_reg    <= '0;
            rx_data   <= 8'h00;
        end else begin
            rx_valid <= 1'b0;
            if (stop_det) begin
                state     <= ST_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                ack_phase <= 1'b0;
            end else if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (byte_done) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state <= ST_A_ACK;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_A_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= '0;
                                if (shreg[0] == I2C_RD) begin
                                    shreg  <= regs[ptr];
                                    sda_oe <= ~regs[ptr][7];
                                    state  <= ST_RD;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= ST_PTR;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (byte_done) begin
                                ptr   <= rx_byte[AW-1:0];
                                state <= ST_P_ACK;
                            end
                        end
                    end
                    ST_WR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (byte_done) begin
                                rx_valid <= 1'b1;
                                rx_reg   <= ptr;
                                rx_data  <= rx_byte;
                                ptr      <= ptr_next;
                                state    <= ST_W_ACK;
                            end
                        end
                    end
                    ST_P_ACK, ST_W_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                bit_cnt   <= '0;
                                state     <= ST_WR;
                            end
                        end
                    end
                    ST_RD: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (byte_done) begin
                                state <= ST_M_ACK;
                            end
                        end else if (scl_fall) begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end
                    ST_M_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b1;
                            end else begin
                                ptr       <= ptr_next;
                                shreg     <= regs[ptr_next];
                                sda_oe    <= ~regs[ptr_next][7];
                                bit_cnt   <= '0;
                                ack_phase <= 1'b0;
                                state     <= ST_RD;
                            end
                        end else if (scl_rise && ack_phase && sda_level) begin
                            ack_phase <= 1'b0;
                            busy      <= 1'b0;
                            state     <= ST_IGNORE;
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an open-drain I2C initiator model plus local-port stimulus.
module tb_i2c_target;

    logic       clk;
    logic       reset;
    logic       scl_m;
    logic       sda_m_low;
    logic       sda_line;
    logic       sda_oe;
    logic       loc_we;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       rx_valid;
    logic [3:0] rx_reg;
    logic [7:0] rx_data;
    logic       busy;

    int tests_run;
    int tests_failed;

    int   rx_regs  [$];
    int   rx_datas [$];
    logic oe_seen;

    assign sda_line = ~(sda_m_low | sda_oe);

    i2c_target #(
        .DEV_ADDR (7'h57),
        .NREG     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .rx_valid  (rx_valid),
        .rx_reg    (rx_reg),
        .rx_data   (rx_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe and any SDA pull by the target.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_regs.push_back(int'(rx_reg));
            rx_datas.push_back(int'(rx_data));
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m_low = 1'b0;
        wait_clks(5);
        scl_m = 1'b1;
        wait_clks(10);
        sda_m_low = 1'b1;
        wait_clks(10);
        scl_m = 1'b0;
        wait_clks(5);
    endtask

    task automatic i2c_stop;
        sda_m_low = 1'b1;
        wait_clks(5);
        scl_m = 1'b1;
        wait_clks(10);
        sda_m_low = 1'b0;
        wait_clks(10);
    endtask

    task automatic write_bit(input logic b);
        sda_m_low = ~b;
        wait_clks(5);
        scl_m = 1'b1;
        wait_clks(10);
        scl_m = 1'b0;
        wait_clks(5);
    endtask

    task automatic read_bit(output logic b);
        sda_m_low = 1'b0;
        wait_clks(5);
        scl_m = 1'b1;
        wait_clks(5);
        b = sda_line;
        wait_clks(5);
        scl_m = 1'b0;
        wait_clks(5);
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] data);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            data[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic loc_write(input logic [3:0] idx, input logic [7:0] val);
        loc_addr  = idx;
        loc_wdata = val;
        loc_we    = 1'b1;
        @(negedge clk);
        loc_we    = 1'b0;
    endtask

    task automatic loc_read(input logic [3:0] idx, output logic [7:0] val);
        loc_addr = idx;
        #1;
        val = loc_rdata;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(1);
        tests_run++;
        if (sda_oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid);
        end
        for (int i = 0; i < 16; i++) begin
            loc_read(4'(i), v);
            tests_run++;
            if (v !== 8'h00) begin
                tests_failed++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 00", i, v);
            end
        end
    endtask

    task automatic test_write;
        logic       a0, a1, a2, a3;
        logic       busy_mid;
        logic [7:0] v3, v4;
        rx_regs.delete();
        rx_datas.delete();
        i2c_start;
        write_byte(8'hAE, a0);
        busy_mid = busy;
        write_byte(8'h03, a1);
        write_byte(8'h5A, a2);
        write_byte(8'hC3, a3);
        i2c_stop;
        loc_read(4'd3, v3);
        loc_read(4'd4, v4);
        tests_run++;
        if ({a0, a1, a2, a3} !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL write_acks: got %b expected 1111", {a0, a1, a2, a3});
        end
        tests_run++;
        if (busy_mid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL write_busy_mid: got %b expected 1", busy_mid);
        end
        tests_run++;
        if (rx_regs.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL write_rx_count: got %0d expected 2", rx_regs.size());
        end else begin
            tests_run++;
            if (rx_regs[0] != 3 || rx_datas[0] != 'h5A) begin
                tests_failed++;
                $display("[TB] FAIL write_rx0: got (%0d,%h) expected (3,5a)", rx_regs[0], rx_datas[0]);
            end
            tests_run++;
            if (rx_regs[1] != 4 || rx_datas[1] != 'hC3) begin
                tests_failed++;
                $display("[TB] FAIL write_rx1: got (%0d,%h) expected (4,c3)", rx_regs[1], rx_datas[1]);
            end
        end
        tests_run++;
        if (v3 !== 8'h5A) begin
            tests_failed++;
            $display("[TB] FAIL write_reg3: got %h expected 5a", v3);
        end
        tests_run++;
        if (v4 !== 8'hC3) begin
            tests_failed++;
            $display("[TB] FAIL write_reg4: got %h expected c3", v4);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_read_wrap;
        logic       a0, a1, a2;
        logic [7:0] d0, d1;
        logic       busy_mid, oe_after;
        loc_write(4'd15, 8'h11);
        loc_write(4'd0, 8'h22);
        i2c_start;
        write_byte(8'hAE, a0);
        write_byte(8'h0F, a1);
        i2c_start;
        write_byte(8'hAF, a2);
        read_byte(1'b1, d0);
        busy_mid = busy;
        read_byte(1'b0, d1);
        oe_after = sda_oe;
        i2c_stop;
        tests_run++;
        if ({a0, a1, a2} !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL read_acks: got %b expected 111", {a0, a1, a2});
        end
        tests_run++;
        if (d0 !== 8'h11) begin
            tests_failed++;
            $display("[TB] FAIL read_byte0: got %h expected 11", d0);
        end
        tests_run++;
        if (d1 !== 8'h22) begin
            tests_failed++;
            $display("[TB] FAIL read_byte1_wrap: got %h expected 22", d1);
        end
        tests_run++;
        if (busy_mid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL read_busy_mid: got %b expected 1", busy_mid);
        end
        tests_run++;
        if (oe_after !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_oe_after_nack: got %b expected 0", oe_after);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_busy_end: got %b expected 0", busy);
        end
    endtask

    // A matching address sent without START must also go unanswered while ignoring.
    task automatic test_mismatch;
        logic a0, a1, busy_mid;
        oe_seen = 1'b0;
        i2c_start;
        write_byte(8'hB0, a0);
        write_byte(8'hAE, a1);
        busy_mid = busy;
        i2c_stop;
        tests_run++;
        if (a0 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mismatch_addr_ack: got %b expected 0", a0);
        end
        tests_run++;
        if (a1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mismatch_ignore_ack: got %b expected 0", a1);
        end
        tests_run++;
        if (oe_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mismatch_oe_seen: got %b expected 0", oe_seen);
        end
        tests_run++;
        if (busy_mid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mismatch_busy: got %b expected 0", busy_mid);
        end
    endtask

    // The I2C register write lands 3 clocks after the 8th SCL rise; loc_we hits exactly that edge.
    task automatic test_collision;
        logic       a0, a1, a2, b;
        logic [7:0] v;
        logic [7:0] data;
        data = 8'h99;
        rx_regs.delete();
        rx_datas.delete();
        i2c_start;
        write_byte(8'hAE, a0);
        write_byte(8'h04, a1);
        for (int i = 7; i >= 1; i--) write_bit(data[i]);
        sda_m_low = ~data[0];
        wait_clks(5);
        scl_m = 1'b1;
        wait_clks(2);
        loc_addr  = 4'd4;
        loc_wdata = 8'h77;
        loc_we    = 1'b1;
        wait_clks(1);
        loc_we    = 1'b0;
        wait_clks(7);
        scl_m = 1'b0;
        wait_clks(5);
        read_bit(b);
        a2 = ~b;
        i2c_stop;
        loc_read(4'd4, v);
        tests_run++;
        if ({a0, a1, a2} !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL coll_acks: got %b expected 111", {a0, a1, a2});
        end
        tests_run++;
        if (v !== 8'h77) begin
            tests_failed++;
            $display("[TB] FAIL coll_reg4: got %h expected 77", v);
        end
        tests_run++;
        if (rx_regs.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL coll_rx_count: got %0d expected 1", rx_regs.size());
        end else begin
            tests_run++;
            if (rx_regs[0] != 4 || rx_datas[0] != 'h99) begin
                tests_failed++;
                $display("[TB] FAIL coll_rx: got (%0d,%h) expected (4,99)", rx_regs[0], rx_datas[0]);
            end
        end
    endtask

    task automatic test_reset_mid_byte;
        logic       a0, a1, a2, a3;
        logic       b7, b6, b5;
        logic       oe_before, oe_reset;
        logic [7:0] v;
        i2c_start;
        write_byte(8'hAE, a0);
        write_byte(8'h07, a1);
        i2c_stop;
        i2c_start;
        write_byte(8'hAF, a2);
        read_bit(b7);
        read_bit(b6);
        read_bit(b5);
        oe_before = sda_oe;
        reset = 1'b1;
        wait_clks(1);
        oe_reset = sda_oe;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(5);
        scl_m = 1'b1;
        wait_clks(10);
        i2c_start;
        write_byte(8'hAE, a3);
        i2c_stop;
        loc_read(4'd4, v);
        tests_run++;
        if ({a0, a1, a2} !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pre_acks: got %b expected 111", {a0, a1, a2});
        end
        tests_run++;
        if ({b7, b6, b5} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_bits: got %b expected 000", {b7, b6, b5});
        end
        tests_run++;
        if (oe_before !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_oe_before: got %b expected 1", oe_before);
        end
        tests_run++;
        if (oe_reset !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_oe_reset: got %b expected 0", oe_reset);
        end
        tests_run++;
        if (a3 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_reack: got %b expected 1", a3);
        end
        tests_run++;
        if (v !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL midrst_reg4_cleared: got %h expected 00", v);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        oe_seen      = 1'b0;
        reset        = 1'b1;
        scl_m        = 1'b1;
        sda_m_low    = 1'b0;
        loc_we       = 1'b0;
        loc_addr     = 4'd0;
        loc_wdata    = 8'h00;
        test_reset;
        test_write;
        test_read_wrap;
        test_mismatch;
        test_collision;
        test_reset_mid_byte;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
